// File: rtl/imem_pkg.sv
// Shared opcode constants, field positions and field-split helper
// for the instruction memory fetch stage.
package imem_pkg;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_ORI  = 6'h10;
  localparam logic [5:0] OP_AND  = 6'h11;
  localparam logic [5:0] OP_OR   = 6'h12;
  localparam logic [5:0] OP_MOVE = 6'h20;
  localparam logic [5:0] OP_SW   = 6'h26;
  localparam logic [5:0] OP_LW   = 6'h27;
  localparam logic [5:0] OP_BEQ  = 6'h30;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
  } instr_fields_t;

  // rd and imm overlap in the word, so fields are sliced, not overlaid
  function automatic instr_fields_t split_instr(input logic [31:0] w);
    instr_fields_t f;
    f.op  = w[OP_MSB:OP_LSB];
    f.rs  = w[RS_MSB:RS_LSB];
    f.rt  = w[RT_MSB:RT_LSB];
    f.rd  = w[RD_MSB:RD_LSB];
    f.imm = w[IMM_MSB:IMM_LSB];
    return f;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction RAM: sync write, registered read,
// write-first when both ports hit the same word.
module imem_ram #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      if (we_i && (waddr_i == raddr_i)) begin
        rdata_q <= wdata_i;
      end else begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch_unit.sv
// Writable instruction memory fetch stage: valid/ready PC fetch,
// registered response, fault/halt status and fetch counter.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter logic [5:0]  HALT_OP = 6'h3F,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [IDX_W-1:0] prog_addr,
  input  logic [31:0]      prog_data,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_pc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_pc,
  output logic [31:0]      rsp_instr,
  output logic [5:0]       op,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      immediate,
  output logic             rsp_fault,
  output logic             halt_seen,
  output logic [CNT_W-1:0] fetch_cnt
);

  logic             accept;
  logic             fault_w;
  logic             halt_now;
  logic             ram_we;
  logic [31:0]      ram_rdata;
  instr_fields_t    fields;

  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic             rsp_fault_q, rsp_fault_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Halt is visible as soon as the halt word is presented
  assign halt_now  = rsp_valid_q && !rsp_fault_q &&
                     (ram_rdata[OP_MSB:OP_LSB] == HALT_OP);
  assign halt_seen = halt_q || halt_now;

  assign req_ready = !halt_seen && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign fault_w   = (req_pc[1:0] != 2'b00) ||
                     (req_pc[31:IDX_W+2] != '0);
  assign ram_we    = prog_we && rst_n;

  imem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .re_i    (accept),
    .raddr_i (req_pc[IDX_W+1:2]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_fault_d = rsp_fault_q;
    cnt_d       = cnt_q;
    halt_d      = halt_q || halt_now;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = req_pc;
      rsp_fault_d = fault_w;
      cnt_d       = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
      rsp_fault_q <= 1'b0;
      halt_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_fault_q <= rsp_fault_d;
      halt_q      <= halt_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_pc    = rsp_pc_q;
  assign rsp_fault = rsp_fault_q;
  assign fetch_cnt = cnt_q;
  assign rsp_instr = rsp_fault_q ? 32'h0 : ram_rdata;

  assign fields    = split_instr(rsp_instr);
  assign op        = fields.op;
  assign rs        = fields.rs;
  assign rt        = fields.rt;
  assign rd        = fields.rd;
  assign immediate = fields.imm;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Randomized and directed bench for imem_fetch_unit against a
// cycle-level behavioural model.
module tb_imem_fetch_unit;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam logic [5:0]  HALT  = 6'h3F;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             prog_we;
  logic [IDX_W-1:0] prog_addr;
  logic [31:0]      prog_data;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_pc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_pc;
  logic [31:0]      rsp_instr;
  logic [5:0]       op;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [15:0]      immediate;
  logic             rsp_fault;
  logic             halt_seen;
  logic [CNT_W-1:0] fetch_cnt;

  imem_fetch_unit #(
    .DEPTH   (DEPTH),
    .HALT_OP (HALT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_pc    (rsp_pc),
    .rsp_instr (rsp_instr),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .immediate (immediate),
    .rsp_fault (rsp_fault),
    .halt_seen (halt_seen),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit [31:0] m_mem [DEPTH];
  bit        m_init  = 0;
  bit        m_valid = 0;
  bit [31:0] m_pc    = 0;
  bit [31:0] m_instr = 0;
  bit        m_fault = 0;
  bit        m_halt  = 0;
  int        m_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rdy);
    bit        acc;
    bit [31:0] w;
    if (!rst_n) begin
      m_init  = 1;
      m_valid = 0;
      m_pc    = 0;
      m_instr = 0;
      m_fault = 0;
      m_halt  = 0;
      m_cnt   = 0;
      return;
    end
    acc = req_valid && rdy;
    if (prog_we) m_mem[prog_addr] = prog_data;
    if (acc) begin
      m_valid = 1;
      m_pc    = req_pc;
      m_fault = (req_pc % 4 != 0) || (req_pc >= DEPTH * 4);
      w       = m_fault ? 32'h0 : m_mem[req_pc / 4];
      m_instr = w;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (!m_fault && (w >> 26) == HALT) m_halt = 1;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs();
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_pc", rsp_pc, m_pc);
    chk("rsp_instr", rsp_instr, m_instr);
    chk("rsp_fault", 32'(rsp_fault), 32'(m_fault));
    chk("halt_seen", 32'(halt_seen), 32'(m_halt));
    chk("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
    chk("op", 32'(op), m_instr >> 26);
    chk("rs", 32'(rs), (m_instr >> 21) & 32'h1F);
    chk("rt", 32'(rt), (m_instr >> 16) & 32'h1F);
    chk("rd", 32'(rd), (m_instr >> 11) & 32'h1F);
    chk("imm", 32'(immediate), m_instr & 32'hFFFF);
  endtask

  task automatic cycle();
    bit exp_rdy;
    exp_rdy = !m_halt && (!m_valid || rsp_ready);
    #1;
    if (m_init) chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    model_edge(exp_rdy);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    prog_we   = 0;
    req_valid = 0;
    rsp_ready = 1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic rr);
    prog_we   = 0;
    req_valid = 1;
    req_pc    = pc;
    rsp_ready = rr;
    cycle();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    cycle();
    rst_n = 1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == HALT) w[31:26] = 6'h01;
    return w;
  endfunction

  logic [31:0] init_w [16];
  logic [31:0] w7;

  initial begin
    rst_n = 0; prog_we = 0; prog_addr = '0; prog_data = '0;
    req_valid = 0; req_pc = '0; rsp_ready = 1;
    cycle();
    cycle();
    rst_n = 1;

    for (int i = 0; i < 16; i++) init_w[i] = rand_word();
    init_w[0]  = 32'h00000000;
    init_w[1]  = 32'h04010008;
    init_w[2]  = 32'h4002000C;
    init_w[3]  = 32'h00221800;
    init_w[12] = 32'hFC000000;
    for (int i = 0; i < 16; i++) begin
      idle();
      prog_we   = 1;
      prog_addr = IDX_W'(i);
      prog_data = init_w[i];
      cycle();
    end
    w7 = init_w[7];

    // Back-to-back fetch of words 0..3
    fetch(0, 1);
    fetch(4, 1);
    chk("pc4_op", 32'(op), 32'h01);
    chk("pc4_rt", 32'(rt), 32'd1);
    chk("pc4_imm", 32'(immediate), 32'h0008);
    fetch(8, 1);
    fetch(12, 1);
    chk("cnt4", 32'(fetch_cnt), 32'd4);
    idle(); cycle();

    // Backpressure hold
    fetch(8, 1);
    for (int i = 0; i < 3; i++) begin
      fetch(12, 0);
      chk("hold_instr", rsp_instr, 32'h4002000C);
    end
    fetch(12, 1);
    chk("release_pc", rsp_pc, 32'd12);
    idle(); cycle();

    // Faults: misaligned and out of range
    fetch(6, 1);
    chk("mis_fault", 32'(rsp_fault), 32'd1);
    fetch(DEPTH * 4, 1);
    chk("oor_instr", rsp_instr, 32'h0);
    idle(); cycle();

    // Halt, then reset and re-fetch
    fetch(48, 1);
    chk("halt_set", 32'(halt_seen), 32'd1);
    for (int i = 0; i < 3; i++) fetch(52, 1);
    do_reset();
    chk("halt_clr", 32'(halt_seen), 32'd0);
    fetch(48, 1);
    chk("refetch48", rsp_instr, 32'hFC000000);
    do_reset();

    // Write-first collision
    req_valid = 1; req_pc = 20; rsp_ready = 1;
    prog_we = 1; prog_addr = IDX_W'(5); prog_data = 32'h44222800;
    cycle();
    chk("wfirst", rsp_instr, 32'h44222800);
    idle(); cycle();

    // Reset drops held response and same-cycle write
    fetch(0, 0);
    idle();
    rsp_ready = 0;
    rst_n = 0;
    prog_we = 1; prog_addr = IDX_W'(7); prog_data = 32'h12345678;
    cycle();
    rst_n = 1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    fetch(28, 1);
    chk("rst_nowrite", rsp_instr, w7);
    idle(); cycle();

    // Random traffic, including counter saturation
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       req_pc = $urandom;
        1:       req_pc = 32'(($urandom_range(0, DEPTH - 1) << 2) | 1);
        default: req_pc = 32'($urandom_range(0, DEPTH - 1) << 2);
      endcase
      prog_we   = ($urandom_range(0, 4) == 0);
      prog_addr = IDX_W'($urandom_range(0, DEPTH - 1));
      prog_data = ($urandom_range(0, 19) == 0) ?
                  {HALT, 26'($urandom)} : rand_word();
      cycle();
    end
    idle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
